// File: rtl/debounce_pkg.sv
// Shared types for the button debouncer: FSM state encoding and a width helper.
// Used by the RTL and by the bench monitor.
package debounce_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      CHK_ON  = 2'd1,
      ON      = 2'd2,
      CHK_OFF = 2'd3
   } db_state_t;

   // Width of a counter that must hold values 0 .. n-1 (at least one bit).
   function automatic int cnt_width(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous level; both flops reset to 0.
// Reusable for any slow board input entering the clk domain.
module sync_2ff (
   input  logic clk,
   input  logic reset,
   input  logic d,
   output logic q
);

   logic meta;

   // First flop may go metastable; second flop gives it a full cycle to settle.
   always_ff @(posedge clk) begin
      if (reset) begin
         meta <= 1'b0;
         q    <= 1'b0;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/button_debouncer.sv
// Button debouncer: raw level -> sync_2ff -> stability counter FSM.
// Produces a clean level plus one-cycle press / release pulses, all registered.
// The release pulse port is named release_pulse because "release" is a reserved word.
// Optional feature: define AUTOREPEAT_EN to emit repeated press pulses every
// REPEAT_CYCLES cycles while the button stays accepted-on.
module button_debouncer
   import debounce_pkg::*;
#(
   parameter int STABLE_CYCLES = 1_000_000,
   parameter int REPEAT_CYCLES = 25_000_000
) (
   input  logic clk,
   input  logic reset,
   input  logic btn_in,
   output logic btn_level,
   output logic press,
   output logic release_pulse,
   output logic bouncing
);

   localparam int CNT_W = cnt_width(STABLE_CYCLES);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

   // Both counts must be at least 2 for the qualification timing to make sense.
   if (STABLE_CYCLES < 2 || REPEAT_CYCLES < 2) begin : g_param_check
      $error("button_debouncer: STABLE_CYCLES and REPEAT_CYCLES must be >= 2");
   end

   logic             sync;
   db_state_t        state, next_state;
   logic [CNT_W-1:0] cnt, next_cnt;
   logic             next_level, next_press, next_release;
   logic             rpt_press;

   sync_2ff u_sync (
      .clk   (clk),
      .reset (reset),
      .d     (btn_in),
      .q     (sync)
   );

`ifdef AUTOREPEAT_EN
   localparam int RPT_W = cnt_width(REPEAT_CYCLES);
   localparam logic [RPT_W-1:0] RPT_LAST = RPT_W'(REPEAT_CYCLES - 1);

   logic [RPT_W-1:0] rpt_cnt, next_rpt_cnt;

   // Repeat timer runs only while staying in ON; anything else parks it at 0.
   always_comb begin
      next_rpt_cnt = '0;
      rpt_press    = 1'b0;
      if (state == ON && sync) begin
         if (rpt_cnt == RPT_LAST) begin
            rpt_press = 1'b1;
         end else begin
            next_rpt_cnt = rpt_cnt + RPT_W'(1);
         end
      end
   end

   // Repeat timer register.
   always_ff @(posedge clk) begin
      if (reset) rpt_cnt <= '0;
      else       rpt_cnt <= next_rpt_cnt;
   end
`else
   assign rpt_press = 1'b0;
`endif

   // Next-state logic; a bounce seen on the terminal count cycle wins over acceptance.
   always_comb begin
      next_state   = state;
      next_cnt     = cnt;
      next_level   = btn_level;
      next_press   = 1'b0;
      next_release = 1'b0;
      case (state)
         IDLE: begin
            if (sync) begin
               next_state = CHK_ON;
               next_cnt   = '0;
            end
         end
         CHK_ON: begin
            if (!sync) begin
               next_state = IDLE;
            end else if (cnt == CNT_LAST) begin
               next_state = ON;
               next_level = 1'b1;
               next_press = 1'b1;
            end else begin
               next_cnt = cnt + CNT_W'(1);
            end
         end
         ON: begin
            if (!sync) begin
               next_state = CHK_OFF;
               next_cnt   = '0;
            end
         end
         CHK_OFF: begin
            if (sync) begin
               next_state = ON;
            end else if (cnt == CNT_LAST) begin
               next_state   = IDLE;
               next_level   = 1'b0;
               next_release = 1'b1;
            end else begin
               next_cnt = cnt + CNT_W'(1);
            end
         end
         default: next_state = IDLE;
      endcase
   end

   // State, counter and all outputs registered together.
   always_ff @(posedge clk) begin
      if (reset) begin
         state         <= IDLE;
         cnt           <= '0;
         btn_level     <= 1'b0;
         press         <= 1'b0;
         release_pulse <= 1'b0;
         bouncing      <= 1'b0;
      end else begin
         state         <= next_state;
         cnt           <= next_cnt;
         btn_level     <= next_level;
         press         <= next_press | rpt_press;
         release_pulse <= next_release;
         bouncing      <= (next_state == CHK_ON) || (next_state == CHK_OFF);
      end
   end

endmodule

// File: tb/tb_button_debouncer.sv
// Directed bench for button_debouncer with STABLE_CYCLES=4, REPEAT_CYCLES=8.
// Build with AUTOREPEAT_EN defined to exercise auto-repeat pulses.
module tb_button_debouncer;
   import debounce_pkg::*;

   localparam int STABLE = 4;
   localparam int REPEAT = 8;
   localparam logic [1:0] EV_PRESS   = 2'd1;
   localparam logic [1:0] EV_RELEASE = 2'd2;

   logic clk = 1'b0;
   logic reset;
   logic btn_in;
   logic btn_level, press, release_pulse, bouncing;

   int tests_run = 0;
   int fails     = 0;
   int both_seen = 0;

   // Expected pulse order: each accepted press/release is pushed before it is due.
   logic [1:0] exp_q[$];

   button_debouncer #(
      .STABLE_CYCLES (STABLE),
      .REPEAT_CYCLES (REPEAT)
   ) dut (
      .clk           (clk),
      .reset         (reset),
      .btn_in        (btn_in),
      .btn_level     (btn_level),
      .press         (press),
      .release_pulse (release_pulse),
      .bouncing      (bouncing)
   );

   // Clock and global time limit.
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL timeout: simulation exceeded time limit");
      $fatal(1, "timeout");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests_run++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Advance n active edges, then settle 1 time unit past the last one.
   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Scoreboard: every pulse seen must be the next expected event.
   always @(negedge clk) begin
      if (reset === 1'b0) begin
         if (press && release_pulse) both_seen++;
         if (press || release_pulse) begin
            tests_run++;
            if (exp_q.size() == 0) begin
               fails++;
               $error("FAIL unexpected_pulse: observed press=%0b release=%0b expected none", press, release_pulse);
            end else begin
               logic [1:0] e;
               logic [1:0] got;
               e   = exp_q.pop_front();
               got = press ? EV_PRESS : EV_RELEASE;
               assert (got === e) else begin
                  fails++;
                  $error("FAIL pulse_order: observed %0d expected %0d", got, e);
               end
            end
         end
      end
   end

   initial begin
      // Reset
      reset  = 1'b1;
      btn_in = 1'b0;
      tick(3);
      check("rst_level", 32'(btn_level), 0);
      check("rst_press", 32'(press), 0);
      check("rst_release", 32'(release_pulse), 0);
      check("rst_bouncing", 32'(bouncing), 0);
      check("rst_state", 32'(dut.state), 32'(IDLE));
      reset = 1'b0;
      tick(2);

      // 1: clean press
      btn_in = 1'b1;
      tick(6);
      check("t1_press_early", 32'(press), 0);
      check("t1_bouncing", 32'(bouncing), 1);
      exp_q.push_back(EV_PRESS);
      tick(1);
      check("t1_press", 32'(press), 1);
      check("t1_level", 32'(btn_level), 1);
      check("t1_bouncing_off", 32'(bouncing), 0);
      tick(1);
      check("t1_press_end", 32'(press), 0);
      check("t1_level_hold", 32'(btn_level), 1);

      // 3: bounce during CHK_OFF, then clean release
      btn_in = 1'b0;
      tick(3);
      check("t3_chk_off", 32'(dut.state), 32'(CHK_OFF));
      btn_in = 1'b1;
      tick(3);
      check("t3_back_on", 32'(dut.state), 32'(ON));
      check("t3_level_kept", 32'(btn_level), 1);
      check("t3_no_release", 32'(release_pulse), 0);
      btn_in = 1'b0;
      tick(6);
      check("t3_release_early", 32'(release_pulse), 0);
      exp_q.push_back(EV_RELEASE);
      tick(1);
      check("t3_release", 32'(release_pulse), 1);
      check("t3_level", 32'(btn_level), 0);
      tick(1);
      check("t3_release_end", 32'(release_pulse), 0);

      // 2: bounce on press
      btn_in = 1'b1;
      tick(3);
      btn_in = 1'b0;
      tick(1);
      btn_in = 1'b1;
      tick(2);
      check("t2_idle", 32'(dut.state), 32'(IDLE));
      check("t2_not_bouncing", 32'(bouncing), 0);
      tick(4);
      check("t2_press_early", 32'(press), 0);
      check("t2_bouncing", 32'(bouncing), 1);
      exp_q.push_back(EV_PRESS);
      tick(1);
      check("t2_press", 32'(press), 1);
      check("t2_level", 32'(btn_level), 1);
      tick(1);
      check("t2_press_end", 32'(press), 0);
      btn_in = 1'b0;
      exp_q.push_back(EV_RELEASE);
      tick(7);
      check("t2_release", 32'(release_pulse), 1);
      tick(1);
      check("t2_level_off", 32'(btn_level), 0);

      // 4: sync drops on the terminal-count cycle
      btn_in = 1'b1;
      tick(4);
      btn_in = 1'b0;
      tick(2);
      check("t4_cnt_term", 32'(dut.cnt), 3);
      check("t4_chk_on", 32'(dut.state), 32'(CHK_ON));
      tick(1);
      check("t4_state", 32'(dut.state), 32'(IDLE));
      check("t4_press", 32'(press), 0);
      check("t4_level", 32'(btn_level), 0);
      tick(3);
      check("t4_level_stays", 32'(btn_level), 0);

      // 5: reset during CHK_ON with the button held
      btn_in = 1'b1;
      tick(5);
      check("t5_cnt2", 32'(dut.cnt), 2);
      reset = 1'b1;
      tick(1);
      check("t5_rst_state", 32'(dut.state), 32'(IDLE));
      check("t5_rst_bouncing", 32'(bouncing), 0);
      tick(2);
      check("t5_rst_level", 32'(btn_level), 0);
      check("t5_rst_press", 32'(press), 0);
      reset = 1'b0;
      tick(6);
      check("t5_press_early", 32'(press), 0);
      exp_q.push_back(EV_PRESS);
      tick(1);
      check("t5_press", 32'(press), 1);
      check("t5_level", 32'(btn_level), 1);

      // 6: long hold, auto-repeat when enabled
`ifdef AUTOREPEAT_EN
      for (int k = 0; k < 3; k++) begin
         tick(7);
         check("t6_rpt_gap", 32'(press), 0);
         exp_q.push_back(EV_PRESS);
         tick(1);
         check("t6_rpt_press", 32'(press), 1);
      end
      tick(2);
`else
      tick(26);
      check("t6_no_repeat", 32'(press), 0);
`endif
      check("t6_level_held", 32'(btn_level), 1);
      btn_in = 1'b0;
      tick(6);
      exp_q.push_back(EV_RELEASE);
      tick(1);
      check("t6_release", 32'(release_pulse), 1);
      check("t6_level_off", 32'(btn_level), 0);
      tick(20);
      check("t6_idle_after", 32'(dut.state), 32'(IDLE));

      // Final bookkeeping
      check("exp_q_drained", 32'(exp_q.size()), 0);
      check("press_release_exclusive", 32'(both_seen), 0);

      $display("[TB] %0d tests run, %0d failed", tests_run, fails);
      $finish;
   end

endmodule
